// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. A clock divider produces the
// pixel tick; horizontal/vertical counters walk the raster using an active
// timing set that can be reloaded at run time (applied only when the raster
// wraps to (0,0)). All raster outputs are registered and always agree with
// the current hpos/vpos.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   en                    global advance enable (gates the divider)
//   cfg_valid/cfg_ready   reload handshake for the cfg_* timing fields
//   cfg_h_*, cfg_v_*      offered horizontal/vertical timing fields
//   cfg_err               one-cycle pulse: offered timing rejected (oversize)
//   irq_line, irq_clr     raster interrupt line select and clear
//   pix_tick              combinational: counters advance this cycle
//   hpos, vpos            registered raster position
//   hsync, vsync          registered syncs, polarity set by *_POL
//   display_on            registered visible-area flag
//   line_start            one-cycle strobe with each new line (hpos=0)
//   frame_start           one-cycle strobe with each new frame (0,0)
//   irq                   sticky raster interrupt
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int   H_BITS    = 10,
  parameter int   V_BITS    = 10,
  parameter int   CLK_DIV   = 1,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_BOTTOM  = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_TOP     = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [H_BITS-1:0] cfg_h_display,
  input  logic [H_BITS-1:0] cfg_h_front,
  input  logic [H_BITS-1:0] cfg_h_sync,
  input  logic [H_BITS-1:0] cfg_h_back,
  input  logic [V_BITS-1:0] cfg_v_display,
  input  logic [V_BITS-1:0] cfg_v_bottom,
  input  logic [V_BITS-1:0] cfg_v_sync,
  input  logic [V_BITS-1:0] cfg_v_top,
  output logic              cfg_err,
  input  logic [V_BITS-1:0] irq_line,
  input  logic              irq_clr,
  output logic              pix_tick,
  output logic [H_BITS-1:0] hpos,
  output logic [V_BITS-1:0] vpos,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic              line_start,
  output logic              frame_start,
  output logic              irq
);

  // Sums of four fields need two extra bits so oversize configs are visible.
  localparam int HW    = H_BITS + 2;
  localparam int VW    = V_BITS + 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [HW-1:0]     H_LIMIT = {2'b01, {H_BITS{1'b0}}};
  localparam logic [VW-1:0]     V_LIMIT = {2'b01, {V_BITS{1'b0}}};
  localparam logic [H_BITS-1:0] H_ONE   = H_BITS'(1);
  localparam logic [V_BITS-1:0] V_ONE   = V_BITS'(1);

  localparam logic [H_BITS-1:0] P_H_DISP  = H_BITS'(H_DISPLAY);
  localparam logic [H_BITS-1:0] P_H_FRONT = H_BITS'(H_FRONT);
  localparam logic [H_BITS-1:0] P_H_SYNC  = H_BITS'(H_SYNC);
  localparam logic [H_BITS-1:0] P_H_BACK  = H_BITS'(H_BACK);
  localparam logic [V_BITS-1:0] P_V_DISP  = V_BITS'(V_DISPLAY);
  localparam logic [V_BITS-1:0] P_V_BOT   = V_BITS'(V_BOTTOM);
  localparam logic [V_BITS-1:0] P_V_SYNC  = V_BITS'(V_SYNC);
  localparam logic [V_BITS-1:0] P_V_TOP   = V_BITS'(V_TOP);

  // Zero-valued fields would collapse a region; treat them as length 1.
  function automatic logic [H_BITS-1:0] h_fix(input logic [H_BITS-1:0] x);
    h_fix = (x == {H_BITS{1'b0}}) ? H_ONE : x;
  endfunction

  function automatic logic [V_BITS-1:0] v_fix(input logic [V_BITS-1:0] x);
    v_fix = (x == {V_BITS{1'b0}}) ? V_ONE : x;
  endfunction

  function automatic logic [HW-1:0] h_sum(input logic [H_BITS-1:0] a, b, c, d);
    h_sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  function automatic logic [VW-1:0] v_sum(input logic [V_BITS-1:0] a, b, c, d);
    v_sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

  // Sync window is [d+f, d+f+s-1]; s is never 0 so the window is non-empty.
  function automatic logic h_in_sync(input logic [H_BITS-1:0] pos, d, f, s);
    logic [HW-1:0] lo;
    logic [HW-1:0] hi;
    lo = {2'b00, d} + {2'b00, f};
    hi = lo + {2'b00, s} - HW'(1);
    h_in_sync = ({2'b00, pos} >= lo) && ({2'b00, pos} <= hi);
  endfunction

  function automatic logic v_in_sync(input logic [V_BITS-1:0] pos, d, f, s);
    logic [VW-1:0] lo;
    logic [VW-1:0] hi;
    lo = {2'b00, d} + {2'b00, f};
    hi = lo + {2'b00, s} - VW'(1);
    v_in_sync = ({2'b00, pos} >= lo) && ({2'b00, pos} <= hi);
  endfunction

  logic [DIV_W-1:0]  r_div_cnt;
  logic [H_BITS-1:0] r_h_disp, r_h_front, r_h_sync, r_h_back;
  logic [V_BITS-1:0] r_v_disp, r_v_bot, r_v_sync, r_v_top;
  logic [H_BITS-1:0] r_sh_h_disp, r_sh_h_front, r_sh_h_sync, r_sh_h_back;
  logic [V_BITS-1:0] r_sh_v_disp, r_sh_v_bot, r_sh_v_sync, r_sh_v_top;
  logic              r_cfg_ready, r_cfg_err;
  logic [H_BITS-1:0] r_hpos;
  logic [V_BITS-1:0] r_vpos;
  logic              r_hsync, r_vsync, r_display_on;
  logic              r_line_start, r_frame_start, r_irq;

  logic              w_tick;
  logic [HW-1:0]     w_h_max;
  logic [VW-1:0]     w_v_max;
  logic              w_h_wrap, w_v_wrap, w_line_wrap, w_frame_wrap, w_load;
  logic [H_BITS-1:0] w_nx_hpos;
  logic [V_BITS-1:0] w_nx_vpos;
  logic [H_BITS-1:0] w_t_h_disp, w_t_h_front, w_t_h_sync;
  logic [V_BITS-1:0] w_t_v_disp, w_t_v_bot, w_t_v_sync;
  logic              w_nx_hsync, w_nx_vsync, w_nx_display_on;
  logic [H_BITS-1:0] w_c_h_disp, w_c_h_front, w_c_h_sync, w_c_h_back;
  logic [V_BITS-1:0] w_c_v_disp, w_c_v_bot, w_c_v_sync, w_c_v_top;
  logic              w_cfg_take, w_cfg_bad, w_irq_set;

  assign w_tick = en && (r_div_cnt == DIV_MAX);

  assign w_h_max  = h_sum(r_h_disp, r_h_front, r_h_sync, r_h_back) - HW'(1);
  assign w_v_max  = v_sum(r_v_disp, r_v_bot, r_v_sync, r_v_top) - VW'(1);
  assign w_h_wrap = ({2'b00, r_hpos} == w_h_max);
  assign w_v_wrap = ({2'b00, r_vpos} == w_v_max);

  assign w_line_wrap  = w_tick && w_h_wrap;
  assign w_frame_wrap = w_line_wrap && w_v_wrap;
  // A pending shadow exists exactly when cfg_ready is low.
  assign w_load       = w_frame_wrap && !r_cfg_ready;

  assign w_nx_hpos = w_h_wrap ? {H_BITS{1'b0}} : (r_hpos + H_ONE);
  assign w_nx_vpos = !w_h_wrap ? r_vpos :
                     (w_v_wrap ? {V_BITS{1'b0}} : (r_vpos + V_ONE));

  // Outputs for the new position use the timing that will be active then,
  // so the wrap tick that loads the shadow already sees the new fields.
  assign w_t_h_disp  = w_load ? r_sh_h_disp  : r_h_disp;
  assign w_t_h_front = w_load ? r_sh_h_front : r_h_front;
  assign w_t_h_sync  = w_load ? r_sh_h_sync  : r_h_sync;
  assign w_t_v_disp  = w_load ? r_sh_v_disp  : r_v_disp;
  assign w_t_v_bot   = w_load ? r_sh_v_bot   : r_v_bot;
  assign w_t_v_sync  = w_load ? r_sh_v_sync  : r_v_sync;

  assign w_nx_hsync = h_in_sync(w_nx_hpos, w_t_h_disp, w_t_h_front, w_t_h_sync)
                      ? HSYNC_POL : ~HSYNC_POL;
  assign w_nx_vsync = v_in_sync(w_nx_vpos, w_t_v_disp, w_t_v_bot, w_t_v_sync)
                      ? VSYNC_POL : ~VSYNC_POL;
  assign w_nx_display_on = (w_nx_hpos < w_t_h_disp) && (w_nx_vpos < w_t_v_disp);

  assign w_c_h_disp  = h_fix(cfg_h_display);
  assign w_c_h_front = h_fix(cfg_h_front);
  assign w_c_h_sync  = h_fix(cfg_h_sync);
  assign w_c_h_back  = h_fix(cfg_h_back);
  assign w_c_v_disp  = v_fix(cfg_v_display);
  assign w_c_v_bot   = v_fix(cfg_v_bottom);
  assign w_c_v_sync  = v_fix(cfg_v_sync);
  assign w_c_v_top   = v_fix(cfg_v_top);

  assign w_cfg_take = cfg_valid && r_cfg_ready;
  assign w_cfg_bad  = (h_sum(w_c_h_disp, w_c_h_front, w_c_h_sync, w_c_h_back) > H_LIMIT) ||
                      (v_sum(w_c_v_disp, w_c_v_bot, w_c_v_sync, w_c_v_top) > V_LIMIT);

  // irq is registered on the same edge as line_start, so it rises with it.
  assign w_irq_set = w_line_wrap && (w_nx_vpos == irq_line);

  // Pixel-clock divider, advancing only on enabled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= {DIV_W{1'b0}};
    end else if (en) begin
      r_div_cnt <= (r_div_cnt == DIV_MAX) ? {DIV_W{1'b0}} : (r_div_cnt + DIV_W'(1));
    end
  end

  // Active/shadow timing and the reload handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_disp     <= P_H_DISP;
      r_h_front    <= P_H_FRONT;
      r_h_sync     <= P_H_SYNC;
      r_h_back     <= P_H_BACK;
      r_v_disp     <= P_V_DISP;
      r_v_bot      <= P_V_BOT;
      r_v_sync     <= P_V_SYNC;
      r_v_top      <= P_V_TOP;
      r_sh_h_disp  <= P_H_DISP;
      r_sh_h_front <= P_H_FRONT;
      r_sh_h_sync  <= P_H_SYNC;
      r_sh_h_back  <= P_H_BACK;
      r_sh_v_disp  <= P_V_DISP;
      r_sh_v_bot   <= P_V_BOT;
      r_sh_v_sync  <= P_V_SYNC;
      r_sh_v_top   <= P_V_TOP;
      r_cfg_ready  <= 1'b1;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_take && w_cfg_bad;
      if (w_cfg_take && !w_cfg_bad) begin
        r_sh_h_disp  <= w_c_h_disp;
        r_sh_h_front <= w_c_h_front;
        r_sh_h_sync  <= w_c_h_sync;
        r_sh_h_back  <= w_c_h_back;
        r_sh_v_disp  <= w_c_v_disp;
        r_sh_v_bot   <= w_c_v_bot;
        r_sh_v_sync  <= w_c_v_sync;
        r_sh_v_top   <= w_c_v_top;
        r_cfg_ready  <= 1'b0;
      end else if (w_load) begin
        r_h_disp    <= r_sh_h_disp;
        r_h_front   <= r_sh_h_front;
        r_h_sync    <= r_sh_h_sync;
        r_h_back    <= r_sh_h_back;
        r_v_disp    <= r_sh_v_disp;
        r_v_bot     <= r_sh_v_bot;
        r_v_sync    <= r_sh_v_sync;
        r_v_top     <= r_sh_v_top;
        r_cfg_ready <= 1'b1;
      end
    end
  end

  // Raster counters, derived outputs and strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hpos        <= {H_BITS{1'b0}};
      r_vpos        <= {V_BITS{1'b0}};
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_display_on  <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_line_wrap;
      r_frame_start <= w_frame_wrap;
      if (w_tick) begin
        r_hpos       <= w_nx_hpos;
        r_vpos       <= w_nx_vpos;
        r_hsync      <= w_nx_hsync;
        r_vsync      <= w_nx_vsync;
        r_display_on <= w_nx_display_on;
      end
    end
  end

  // Sticky raster interrupt; a set beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_irq <= 1'b1;
    end else if (irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign pix_tick    = w_tick;
  assign cfg_ready   = r_cfg_ready;
  assign cfg_err     = r_cfg_err;
  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign irq         = r_irq;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. dut0: CLK_DIV=1, active-low syncs, a small
// 24x10 raster (16/2/4/2, 6/1/2/1) checked cycle by cycle against a
// behavioural raster model. dut1: CLK_DIV=4, active-high syncs, same raster,
// driven from a table of enable patterns.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, en0, en1, cfg_valid0, irq_clr0;
  logic [9:0] ch [4];
  logic [9:0] cv [4];
  logic [9:0] irq_line0;

  logic       cfg_ready0, cfg_err0, pix_tick0, hsync0, vsync0, disp0, ls0, fs0, irq0;
  logic [9:0] hpos0, vpos0;
  logic       cfg_ready1, cfg_err1, pix_tick1, hsync1, vsync1, disp1, ls1, fs1, irq1;
  logic [9:0] hpos1, vpos1;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .H_BITS(10), .V_BITS(10), .CLK_DIV(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1)
  ) dut0 (
    .clk(clk), .reset(rst0), .en(en0), .cfg_valid(cfg_valid0), .cfg_ready(cfg_ready0),
    .cfg_h_display(ch[0]), .cfg_h_front(ch[1]), .cfg_h_sync(ch[2]), .cfg_h_back(ch[3]),
    .cfg_v_display(cv[0]), .cfg_v_bottom(cv[1]), .cfg_v_sync(cv[2]), .cfg_v_top(cv[3]),
    .cfg_err(cfg_err0), .irq_line(irq_line0), .irq_clr(irq_clr0), .pix_tick(pix_tick0),
    .hpos(hpos0), .vpos(vpos0), .hsync(hsync0), .vsync(vsync0), .display_on(disp0),
    .line_start(ls0), .frame_start(fs0), .irq(irq0)
  );

  vga_timing_gen #(
    .H_BITS(10), .V_BITS(10), .CLK_DIV(4), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(6), .V_BOTTOM(1), .V_SYNC(2), .V_TOP(1)
  ) dut1 (
    .clk(clk), .reset(rst1), .en(en1), .cfg_valid(1'b0), .cfg_ready(cfg_ready1),
    .cfg_h_display(10'd0), .cfg_h_front(10'd0), .cfg_h_sync(10'd0), .cfg_h_back(10'd0),
    .cfg_v_display(10'd0), .cfg_v_bottom(10'd0), .cfg_v_sync(10'd0), .cfg_v_top(10'd0),
    .cfg_err(cfg_err1), .irq_line(10'd1023), .irq_clr(1'b0), .pix_tick(pix_tick1),
    .hpos(hpos1), .vpos(vpos1), .hsync(hsync1), .vsync(vsync1), .display_on(disp1),
    .line_start(ls1), .frame_start(fs1), .irq(irq1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut0 ----------------
  int m_h, m_v, m_line, m_frame, m_irq, m_rdy, m_err;
  int a_h [4];
  int a_v [4];
  int s_h [4];
  int s_v [4];

  task automatic model_reset();
    a_h = '{16, 2, 4, 2};
    a_v = '{6, 1, 2, 1};
    m_h = 0; m_v = 0; m_line = 0; m_frame = 0; m_irq = 0; m_rdy = 1; m_err = 0;
  endtask

  task automatic model_edge();
    int fh [4];
    int fv [4];
    int rdy_n;
    rdy_n = m_rdy;
    m_err = 0;
    if (cfg_valid0 && (m_rdy == 1)) begin
      for (int i = 0; i < 4; i++) begin
        fh[i] = (ch[i] == 10'd0) ? 1 : int'(ch[i]);
        fv[i] = (cv[i] == 10'd0) ? 1 : int'(cv[i]);
      end
      if ((fh[0] + fh[1] + fh[2] + fh[3] > 1024) || (fv[0] + fv[1] + fv[2] + fv[3] > 1024)) begin
        m_err = 1;
      end else begin
        s_h = fh; s_v = fv; rdy_n = 0;
      end
    end
    m_line = 0; m_frame = 0;
    if (en0) begin
      if (m_h == a_h[0] + a_h[1] + a_h[2] + a_h[3] - 1) begin
        m_h = 0; m_line = 1;
        if (m_v == a_v[0] + a_v[1] + a_v[2] + a_v[3] - 1) begin
          m_v = 0; m_frame = 1;
          if (m_rdy == 0) begin a_h = s_h; a_v = s_v; rdy_n = 1; end
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
    if ((m_line == 1) && (m_v == int'(irq_line0))) m_irq = 1;
    else if (irq_clr0) m_irq = 0;
    m_rdy = rdy_n;
  endtask

  task automatic compare_all();
    int lo_h, lo_v;
    lo_h = a_h[0] + a_h[1];
    lo_v = a_v[0] + a_v[1];
    check("hpos", hpos0, m_h);
    check("vpos", vpos0, m_v);
    check("hsync", hsync0, ((m_h >= lo_h) && (m_h < lo_h + a_h[2])) ? 0 : 1);
    check("vsync", vsync0, ((m_v >= lo_v) && (m_v < lo_v + a_v[2])) ? 0 : 1);
    check("display_on", disp0, ((m_h < a_h[0]) && (m_v < a_v[0])) ? 1 : 0);
    check("line_start", ls0, m_line);
    check("frame_start", fs0, m_frame);
    check("irq", irq0, m_irq);
    check("cfg_ready", cfg_ready0, m_rdy);
    check("cfg_err", cfg_err0, m_err);
    if (!rst0) check("pix_tick", pix_tick0, en0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input int h0, h1, h2, h3, v0, v1, v2, v3);
    ch[0] = 10'(h0); ch[1] = 10'(h1); ch[2] = 10'(h2); ch[3] = 10'(h3);
    cv[0] = 10'(v0); cv[1] = 10'(v1); cv[2] = 10'(v2); cv[3] = 10'(v3);
  endtask

  // ---------------- dut1 divider table ----------------
  // mode: 0 = en held 1, 1 = en toggles 1,0,..., 2 = en held 0
  typedef struct {
    int   mode;
    int   edges;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic disp;
    logic tick;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int n, f1, f2;

    tbl[0]  = '{0,  3,  0, 0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{2,  5,  0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{0,  1,  1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{0,  4,  2, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{0, 64, 18, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{0, 16, 22, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0,  8,  0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1,  8,  1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1,  8,  2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1,  4,  2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1,  4,  3, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{2, 20,  3, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{0,  4,  4, 1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b1; en1 = 1'b1;
    cfg_valid0 = 1'b0; irq_clr0 = 1'b0; irq_line0 = 10'd1023;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset held across clock edges: nothing advances.
    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    check("dut1_rst_hsync", hsync1, 0);
    check("dut1_rst_hpos", hpos1, 0);
    check("dut1_rst_ready", cfg_ready1, 1);

    // Divider table on dut1.
    @(negedge clk);
    rst1 = 1'b0;
    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < tbl[r].edges; k++) begin
        en1 = (tbl[r].mode == 0) ? 1'b1 : ((tbl[r].mode == 1) ? ((k % 2) == 0) : 1'b0);
        @(posedge clk);
        #1;
      end
      check($sformatf("div_vec%0d_hpos", r), hpos1, tbl[r].h);
      check($sformatf("div_vec%0d_vpos", r), vpos1, tbl[r].v);
      check($sformatf("div_vec%0d_hsync", r), hsync1, tbl[r].hs);
      check($sformatf("div_vec%0d_vsync", r), vsync1, tbl[r].vs);
      check($sformatf("div_vec%0d_disp", r), disp1, tbl[r].disp);
      check($sformatf("div_vec%0d_tick", r), pix_tick1, tbl[r].tick);
    end
    en1 = 1'b0;

    // Release dut0; first tick gives hpos=1, then two full default frames.
    @(negedge clk);
    rst0 = 1'b0;
    step();
    check("first_tick_hpos", hpos0, 1);
    f1 = -1; f2 = -1;
    for (int e = 2; e <= 500; e++) begin
      step();
      if (fs0 === 1'b1) begin
        if (f1 < 0) f1 = e;
        else if (f2 < 0) f2 = e;
      end
    end
    check("first_frame_edge", f1, 240);
    check("frame_period", f2 - f1, 240);

    // Asynchronous reset mid-line (no clock edge involved).
    #2 rst0 = 1'b1;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst0 = 1'b0;
    step();
    check("restart_hpos", hpos0, 1);

    // Mid-frame reload, including a zero field and an ignored second offer.
    n = 0;
    while (!((m_v == 3) && (m_h == 5)) && (n < 1000)) begin step(); n++; end
    check("reach_v3", m_v, 3);
    set_cfg(8, 2, 3, 0, 4, 1, 1, 2);
    cfg_valid0 = 1'b1;
    step();
    check("reload_ready_drop", cfg_ready0, 0);
    set_cfg(5, 5, 5, 5, 5, 5, 5, 5);
    step();
    cfg_valid0 = 1'b0;
    n = 0;
    while ((fs0 !== 1'b1) && (n < 1000)) begin step(); n++; end
    check("reload_wrap_seen", fs0, 1);
    check("reload_ready_back", cfg_ready0, 1);
    n = 0;
    do begin step(); n++; end while ((fs0 !== 1'b1) && (n < 1000));
    check("new_frame_period", n, 112);

    // Oversize horizontal config is rejected.
    set_cfg(1000, 16, 96, 48, 4, 1, 1, 2);
    cfg_valid0 = 1'b1;
    step();
    cfg_valid0 = 1'b0;
    check("oversize_err", cfg_err0, 1);
    check("oversize_ready", cfg_ready0, 1);
    step();
    check("err_one_cycle", cfg_err0, 0);
    repeat (120) step();

    // Exactly 2^H_BITS is accepted; reset then discards the pending shadow.
    set_cfg(1000, 8, 8, 8, 4, 1, 1, 2);
    cfg_valid0 = 1'b1;
    step();
    cfg_valid0 = 1'b0;
    check("limit_accept_ready", cfg_ready0, 0);
    check("limit_no_err", cfg_err0, 0);
    repeat (5) step();
    #2 rst0 = 1'b1;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    rst0 = 1'b0;
    n = 0;
    do begin step(); n++; end while ((fs0 !== 1'b1) && (n < 1000));
    check("post_reset_frame", n, 240);

    // Raster interrupt: set with a simultaneous clear, then a plain clear.
    irq_line0 = 10'd2;
    n = 0;
    while (!((m_h == 23) && (m_v == 1)) && (n < 1000)) begin step(); n++; end
    check("irq_pre", irq0, 0);
    irq_clr0 = 1'b1;
    step();
    irq_clr0 = 1'b0;
    check("irq_set_wins", irq0, 1);
    check("irq_with_line_start", ls0, 1);
    check("irq_vpos", vpos0, 2);
    repeat (5) step();
    irq_clr0 = 1'b1;
    step();
    irq_clr0 = 1'b0;
    check("irq_cleared", irq0, 0);
    repeat (240) step();
    check("irq_next_frame", irq0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It is the next generation of the fixed 640x480 sync generator and adds:
- configurable counter widths and an internal pixel-clock divider;
- selectable sync polarity;
- run-time timing reload, applied only at frame boundaries;
- line/frame strobes and a raster-line interrupt.

It sits between the system clock domain and the pixel pipeline, which consumes `hpos`/`vpos`/`display_on`.

## Interface
- `H_BITS`, 10: width of `hpos` and the horizontal config fields.
- `V_BITS`, 10: width of `vpos` and the vertical config fields.
- `CLK_DIV`, 1: `clk` cycles per pixel (≥1).
- `HSYNC_POL`, 0: active level of `hsync`.
- `VSYNC_POL`, 0: active level of `vsync`.
- `H_DISPLAY`/`H_FRONT`/`H_SYNC`/`H_BACK`, 640/16/96/48: reset horizontal timing.
- `V_DISPLAY`/`V_BOTTOM`/`V_SYNC`/`V_TOP`, 480/10/2/33: reset vertical timing.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  global advance enable, gating the divider.
- `cfg_valid`  in  1  new timing offered.
- `cfg_ready`  out  1  no reload pending.
- `cfg_h_display`, `cfg_h_front`, `cfg_h_sync`, `cfg_h_back`  in  H_BITS each  horizontal timing fields.
- `cfg_v_display`, `cfg_v_bottom`, `cfg_v_sync`, `cfg_v_top`  in  V_BITS each  vertical timing fields.
- `cfg_err`  out  1  one-cycle pulse: offered config rejected.
- `irq_line`  in  V_BITS  line that sets `irq`.
- `irq_clr`  in  1  clears `irq`.
- `pix_tick`  out  1  combinational: counters advance this cycle.
- `hpos`  out  H_BITS  registered horizontal position.
- `vpos`  out  V_BITS  registered vertical position.
- `hsync`, `vsync`, `display_on`  out  1 each  registered, aligned with `hpos`/`vpos`.
- `line_start`, `frame_start`  out  1 each  one-cycle strobes.
- `irq`  out  1  sticky raster interrupt.

## Operation
**Divider**
- `div_cnt` counts 0..CLK_DIV-1 on cycles with `en`=1.
- `pix_tick` = `en` && (`div_cnt` == CLK_DIV-1). With CLK_DIV=1, `pix_tick` = `en`.

**Active timing**
- Active timing registers: h_total = display+front+sync+back, h_max = h_total-1; vertical likewise.
- Sums are computed H_BITS+2 (V_BITS+2) bits wide.

**Counters**
- On `pix_tick`: if `hpos` == h_max, `hpos` ← 0 and `vpos` advances (wrapping at v_max to 0); otherwise `hpos`+1.
- On non-tick cycles, all counter-derived outputs hold.

**Derived outputs** (registered; must equal these functions of the current `hpos`/`vpos` every cycle)
- `hsync` = HSYNC_POL when d+f ≤ `hpos` ≤ d+f+s-1, using the horizontal display/front/sync fields; else ~HSYNC_POL.
- `vsync` uses the same rule with the vertical fields.
- `display_on` = (`hpos` < h_display) && (`vpos` < v_display).

**Strobes**
- `line_start` pulses in the cycle after a tick that wrapped `hpos` to 0.
- `frame_start` pulses in the cycle after a tick that wrapped both counters to 0; `line_start` pulses with it.
- Neither strobe fires after reset.

**irq**
- Set when `line_start` and `vpos` == `irq_line`.
- Cleared by `irq_clr`; set wins if both occur in the same cycle.

**Reload handshake**
- Accept on `cfg_valid` && `cfg_ready`. Zero-valued fields are captured as 1.
- If the computed h_total > 2^H_BITS or v_total > 2^V_BITS: discard the config, pulse `cfg_err` next cycle, leave `cfg_ready`=1.
- Otherwise latch into shadow registers and drop `cfg_ready` the next cycle.
- Shadow is copied to active on the tick that wraps to (0,0); that same tick's output computation uses the new timing.
- `cfg_ready` returns to 1 the cycle after the copy.
- `cfg_valid` while `cfg_ready`=0 is ignored.

## Timing
- Reset (async) values: `hpos`=0, `vpos`=0, `div_cnt`=0, `hsync`=~HSYNC_POL, `vsync`=~VSYNC_POL, `display_on`=1, `line_start`=0, `frame_start`=0, `irq`=0, `cfg_ready`=1, `cfg_err`=0.
- Reset restores the parameter timing and discards any pending shadow.
- Latency: counter/output update 1 `clk` after the `pix_tick` cycle. Strobes coincide with the new `hpos`=0.
- Frame period = h_total·v_total·CLK_DIV cycles with `en`=1.
- Reset mid-frame: outputs return to reset values immediately; counting restarts from (0,0) on the first `pix_tick`.

## Test plan
- **Reset values:** assert `reset` mid-line with defaults → all outputs take their reset values asynchronously; after release, the first `pix_tick` gives `hpos`=1.
- **Default frame:** CLK_DIV=1, `en`=1, defaults → `frame_start` every 420000 cycles; `hsync`=0 exactly for `hpos` 656..751; `vsync`=0 for `vpos` 490..491; `display_on` for `hpos`<640 && `vpos`<480.
- **Divider:** CLK_DIV=4 → `hpos` increments every 4 cycles; with `en` toggling 1,0 → increments every 8 cycles.
- **Mid-frame reload:** offer 320/8/48/24 × 240/5/1/16 at `vpos`=100 → `cfg_ready`=0 until wrap; previous frame unchanged; next frame h_total=400, v_total=262; `hsync` at `hpos` 328..375.
- **Oversize config:** h fields 1000/16/96/48 with H_BITS=10 → `cfg_err` pulse; timing unchanged; `cfg_ready` stays 1.
- **Raster interrupt:** `irq_line`=200 → `irq` rises with `line_start` at `vpos`=200; `irq_clr` asserted in the same cycle as the set → `irq` stays 1; a later `irq_clr` clears it.
